// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: data type, FSM states,
// RV32I load/store funct3 encodings and lane/extension helpers.
package dmem_resp_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

  // sz is funct3[1:0]: 0 = byte, 1 = halfword, 2 = word
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    case (sz)
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic data_t store_lanes(input logic [1:0] sz, input data_t d);
    data_t r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic data_t load_extend(input logic [2:0] f3, input logic [1:0] off,
                                        input data_t word);
    data_t sh;
    data_t r;
    sh = word >> {off, 3'b000};
    case (f3)
      F3_LB:   r = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   r = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  r = {24'h000000, sh[7:0]};
      F3_LHU:  r = {16'h0000, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array with four byte-lane write enables.
// Contents are deliberately never reset.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  data_t         wdata,
  output data_t         rdata
);

  data_t mem [DEPTH_WORDS];

  // Lane writes and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request, programmable wait latency,
// one-cycle response strobe with RV32I load extension and error checking.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  data_t       req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int         AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT = 4'(LATENCY);

  dmem_state_t state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  logic        enter_resp_s;
  logic        ready_r, busy_r, valid_r, err_r;
  data_t       hold_r, rdata_s;
  logic        lat_we_r;
  data_t       lat_addr_r;
  logic [31:0] lat_wdata_r;
  logic [2:0]  lat_f3_r;
  logic        cur_we_s, err_s;
  data_t       cur_addr_s;
  logic [31:0] cur_wdata_s;
  logic [2:0]  cur_f3_s;
  logic [3:0]  wen_s;
  data_t       arr_rdata_s;

  // With LATENCY=0 the access happens on the handshake edge, so use the live inputs in IDLE
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_we_s    = req_we;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
      cur_f3_s    = req_funct3;
    end else begin
      cur_we_s    = lat_we_r;
      cur_addr_s  = lat_addr_r;
      cur_wdata_s = lat_wdata_r;
      cur_f3_s    = lat_f3_r;
    end
    err_s = !f3_legal(cur_we_s, cur_f3_s) ||
            misaligned(cur_f3_s[1:0], cur_addr_s[1:0]) ||
            ({2'b00, cur_addr_s[31:2]} >= 32'(DEPTH_WORDS));
    if (enter_resp_s && cur_we_s && !err_s) begin
      wen_s = lane_mask(cur_f3_s[1:0], cur_addr_s[1:0]);
    end else begin
      wen_s = 4'b0000;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (LAT == 4'd0) begin
            state_n      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = LAT;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_n      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counter and registered handshake/response flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      hold_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ready_r <= (state_n == ST_IDLE);
      busy_r  <= (state_n != ST_IDLE);
      valid_r <= (state_n == ST_RESP);
      if (enter_resp_s) begin
        err_r <= err_s;
      end
      if (state_r == ST_RESP) begin
        hold_r <= rdata_s;
      end
    end
  end

  // Request capture on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we_r    <= 1'b0;
      lat_addr_r  <= 32'h0000_0000;
      lat_wdata_r <= 32'h0000_0000;
      lat_f3_r    <= 3'b000;
    end else if (req_valid && req_ready) begin
      lat_we_r    <= req_we;
      lat_addr_r  <= req_addr;
      lat_wdata_r <= req_wdata;
      lat_f3_r    <= req_funct3;
    end
  end

  // Array read data is only meaningful during RESP; otherwise the last response is held
  always_comb begin
    rdata_s = hold_r;
    if (state_r == ST_RESP) begin
      if (err_r || lat_we_r) begin
        rdata_s = 32'h0000_0000;
      end else begin
        rdata_s = load_extend(lat_f3_r, lat_addr_r[1:0], arr_rdata_s);
      end
    end else begin
      rdata_s = hold_r;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .wen  (wen_s),
    .addr (cur_addr_s[AW+1:2]),
    .wdata(store_lanes(cur_f3_s[1:0], cur_wdata_s)),
    .rdata(arr_rdata_s)
  );

  assign req_ready  = ready_r;
  assign busy       = busy_r;
  assign resp_valid = valid_r;
  assign resp_err   = err_r;
  assign resp_rdata = rdata_s;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized self-checking bench for dmem_resp against a byte-addressed
// behavioural memory model, plus directed literal checks and a LATENCY=0 instance.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int DEPTH  = 256;
  localparam int LAT    = 2;
  localparam int ZDEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        z_valid = 1'b0, z_we = 1'b0;
  logic [31:0] z_addr = 32'h0, z_wdata = 32'h0;
  logic [2:0]  z_f3 = 3'b000;
  logic        z_ready, z_resp_valid, z_err, z_busy;
  logic [31:0] z_rdata;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dmem_resp #(.DEPTH_WORDS(ZDEPTH), .LATENCY(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_addr(z_addr), .req_wdata(z_wdata),
    .req_funct3(z_f3), .resp_valid(z_resp_valid), .resp_rdata(z_rdata),
    .resp_err(z_err), .busy(z_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mem_m [0:4*DEPTH-1];
  logic        pend = 1'b0;
  int          pend_due = 0;
  logic        pend_we = 1'b0;
  logic [2:0]  pend_f3 = 3'b000;
  logic [31:0] pend_addr = 32'h0, pend_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err = 1'b0;
  int          n_hs = 0, n_rv = 0, n_drop = 0;

  function automatic void model_resp(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] d, output logic [31:0] rd, output logic er);
    int          nbytes;
    logic        legal;
    logic [31:0] v;
    legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = 1 << f3[1:0];
    er     = !legal || ((a % nbytes) != 0) || ((a >> 2) >= DEPTH);
    rd     = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < nbytes; i++) mem_m[a + i] = d[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = mem_m[a + i];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endfunction

  // Per-cycle compare of every output against the model, then handshake detection
  always @(negedge clk) begin
    logic exp_busy, exp_valid;
    if (!rst_n) begin
      if (pend) n_drop++;
      pend    = 1'b0;
      m_rdata = 32'h0;
      m_err   = 1'b0;
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_err", resp_err, 0);
    end else begin
      exp_busy  = pend;
      exp_valid = pend && (cyc == pend_due);
      if (exp_valid) begin
        model_resp(pend_we, pend_f3, pend_addr, pend_wdata, m_rdata, m_err);
        pend = 1'b0;
      end
      if (resp_valid) n_rv++;
      chk("resp_valid", resp_valid, exp_valid);
      chk("busy", busy, exp_busy);
      chk("req_ready", req_ready, !exp_busy);
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", resp_err, m_err);
      if (req_valid && !exp_busy) begin
        pend       = 1'b1;
        pend_due   = cyc + LAT + 1;
        pend_we    = req_we;
        pend_f3    = req_funct3;
        pend_addr  = req_addr;
        pend_wdata = req_wdata;
        n_hs++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] pre(input int w);
    return (32'(w) * 32'h0101_0101) ^ 32'h5A00_C300;
  endfunction

  task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output int hc);
    int n = 0;
    @(posedge clk); #1;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("hs_timeout", req_ready, 1);
    hc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
    int hc, n;
    start_req(we, f3, a, d, hc);
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 40);
    chk("resp_timeout", resp_valid, 1);
    rd  = resp_rdata;
    er  = resp_err;
    lat = cyc - hc;
  endtask

  task automatic rand_req();
    int sel;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_wdata  = $urandom;
    sel        = int'($urandom_range(0, 9));
    if (sel == 0)      req_addr = $urandom;
    else if (sel == 1) req_addr = 32'(4*DEPTH - 4) + 32'($urandom_range(0, 7));
    else               req_addr = 32'($urandom_range(0, 127));
  endtask

  task automatic z_txn(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    z_we = we; z_f3 = f3; z_addr = a; z_wdata = d; z_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_ready"}, z_ready, 1);
    @(posedge clk); #1;
    z_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, z_resp_valid, 1);
    chk({nm, "_rdata"}, z_rdata, exp_rd);
    chk({nm, "_err"}, z_err, exp_err);
    chk({nm, "_busy"}, z_busy, 1);
    @(negedge clk);
    chk({nm, "_valid_end"}, z_resp_valid, 0);
    chk({nm, "_ready_back"}, z_ready, 1);
    chk({nm, "_rdata_hold"}, z_rdata, exp_rd);
    chk({nm, "_err_hold"}, z_err, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, hc;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int w = 0; w < DEPTH; w++) txn(1'b1, F3_SW, 32'(4*w), pre(w), rd, er, lat);

    txn(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, rd, er, lat);
    chk("sw100_latency", lat, 3); chk("sw100_err", er, 0); chk("sw100_rdata", rd, 0);
    txn(1'b0, F3_LW, 32'h100, 32'h0, rd, er, lat);
    chk("lw100", rd, 32'hDEADBEEF); chk("lw100_err", er, 0);
    txn(1'b1, F3_SB, 32'h101, 32'h80, rd, er, lat);
    chk("sb101_err", er, 0);
    txn(1'b0, F3_LB, 32'h101, 32'h0, rd, er, lat);
    chk("lb101", rd, 32'hFFFFFF80);
    txn(1'b0, F3_LBU, 32'h101, 32'h0, rd, er, lat);
    chk("lbu101", rd, 32'h00000080);
    txn(1'b0, F3_LW, 32'h100, 32'h0, rd, er, lat);
    chk("lw100_after_sb", rd, 32'hDEAD80EF);
    txn(1'b0, F3_LW, 32'h102, 32'h0, rd, er, lat);
    chk("lw102_err", er, 1); chk("lw102_rdata", rd, 0);
    txn(1'b1, F3_SH, 32'h103, 32'h1234, rd, er, lat);
    chk("sh103_err", er, 1);
    txn(1'b1, 3'b011, 32'h100, 32'h0, rd, er, lat);
    chk("store_illegal_f3_err", er, 1);
    txn(1'b1, F3_SW, 32'(4*DEPTH), 32'h0, rd, er, lat);
    chk("sw_oor_err", er, 1);
    txn(1'b0, F3_LW, 32'h100, 32'h0, rd, er, lat);
    chk("lw100_unchanged", rd, 32'hDEAD80EF);
    txn(1'b0, F3_LHU, 32'(4*DEPTH - 2), 32'h0, rd, er, lat);
    chk("lhu_last_word", rd, {16'h0000, pre(DEPTH - 1) >> 16}); chk("lhu_last_err", er, 0);

    // Reset pulsed while the store waits: nothing must be written
    start_req(1'b1, F3_SW, 32'h200, 32'h12345678, hc);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", req_ready, 1); chk("midrst_valid", resp_valid, 0);
    chk("midrst_busy", busy, 0); chk("midrst_rdata", resp_rdata, 0); chk("midrst_err", resp_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    txn(1'b0, F3_LW, 32'h200, 32'h0, rd, er, lat);
    chk("lw200_prior", rd, pre(128));

    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      rand_req();
      req_valid = ($urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      rand_req();
      req_valid = 1'b1;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("resp_count", n_rv, n_hs - n_drop);

    z_txn("z_lw_oor", 1'b0, F3_LW, 32'(4*ZDEPTH), 32'h0, 32'h0, 1'b1);
    z_txn("z_sw8", 1'b1, F3_SW, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0);
    z_txn("z_lw8", 1'b0, F3_LW, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0);
    z_txn("z_lh10", 1'b0, F3_LH, 32'hA, 32'h0, 32'hFFFFCAFE, 1'b0);
    z_txn("z_lhu10", 1'b0, F3_LHU, 32'hA, 32'h0, 32'h0000CAFE, 1'b0);
    z_txn("z_st_badf3", 1'b1, 3'b100, 32'h8, 32'h0, 32'h0, 1'b1);
    z_txn("z_lw8_kept", 1'b0, F3_LW, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the array.
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles inserted before the access, legal range 0..15.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  initiator presents a request.
REQ-006 SHALL have port req_ready  out  1  responder can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  in  32  byte address (data_t).
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port req_funct3  in  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-011 SHALL have port resp_valid  out  1  one-cycle response strobe.
REQ-012 SHALL have port resp_rdata  out  32  extended load data.
REQ-013 SHALL have port resp_err  out  1  request rejected: misaligned, out of range or illegal funct3.
REQ-014 SHALL have port busy  out  1  request in flight; drives pipeline stall.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; handshake = req_valid && req_ready.
REQ-017 SHALL latch we/addr/wdata/funct3 on handshake; inputs ignored otherwise.
REQ-018 On handshake SHALL load the wait counter with LATENCY and enter WAIT; when LATENCY=0, SHALL enter RESP directly.
REQ-019 In WAIT SHALL decrement the counter each cycle and enter RESP on the cycle the counter reads 0.
REQ-020 SHALL perform the array read/write on the transition into RESP; resp_valid=1 for exactly one cycle in RESP; then IDLE.
REQ-021 Latency, handshake edge to resp_valid, SHALL be LATENCY+1 cycles; the next handshake SHALL occur no earlier than the cycle after RESP.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 SB SHALL write byte lane addr[1:0]; SH SHALL write halfword lane addr[1]; SW SHALL write all 4 lanes; unwritten lanes SHALL be preserved.
REQ-024 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL be unmodified.
REQ-025 LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL set resp_err=1 and perform no write.
REQ-026 addr[31:2] >= DEPTH_WORDS, or funct3 not a legal load/store encoding for req_we, SHALL set resp_err=1 and perform no write.
REQ-027 On error, and for every store, resp_rdata SHALL be 0.
REQ-028 resp_rdata/resp_err SHALL hold their last value until the next RESP.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
REQ-030 Reset mid-operation SHALL discard the pending request; no write occurs unless RESP was already entered.
REQ-031 Array contents SHALL NOT be reset.

Structure
REQ-032 dmem_state_t and the funct3 load/store constants SHALL live in the shared defines package; data_t SHALL be reused.
REQ-033 Storage SHALL be a sub-module dmem_array: single-port, 4 byte-lane write enables, DEPTH_WORDS words, synchronous.

Verification
REQ-034 LATENCY=2, SW 0x100 data 0xDEADBEEF -> resp_valid 3 cycles after handshake, err=0; LW 0x100 -> rdata 0xDEADBEEF.
REQ-035 SB 0x101 data 0x80, then LB 0x101 -> 0xFFFFFF80; LBU 0x101 -> 0x00000080; LW 0x100 -> 0xDEAD80EF.
REQ-036 LW 0x102 -> resp_err=1, rdata=0; SH 0x103 -> err=1, word 0x100 unchanged.
REQ-037 LATENCY=0, LW addr 4*DEPTH_WORDS -> resp_valid 1 cycle after handshake, err=1.
REQ-038 rst_n pulsed low during WAIT of SW 0x200 data 0x12345678 -> outputs at reset values; LW 0x200 returns prior content.
REQ-039 req_valid held high continuously -> req_ready low for LATENCY+1 cycles after each handshake; exactly one resp_valid per accepted request.
